// File: rtl/math_pkg.sv
// Shared definitions for the iterative math units (squarer, square root).
// Holds the common IDLE/COUNT state type and the result-width sanity check.
package math_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } iter_state_e;

    function automatic bit dw_is_valid(input int unsigned dw);
        return (dw % 2 == 0) && (dw >= 4);
    endfunction

endpackage

// File: rtl/square_iter.sv
// Iterative shift-and-add squarer: p = a*a, one multiplier bit per cycle.
// Define SQUARE_ITER_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module square_iter
    import math_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic [DW/2-1:0] a,
    output logic            done,
    output logic [DW-1:0]   p
);

    localparam int unsigned HW = DW / 2;
    localparam int unsigned CW = $clog2(HW + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(HW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (!dw_is_valid(DW)) begin : g_dw_check
        $error("square_iter: DW must be even and >= 4");
    end

    iter_state_e     state_q, state_d;
    logic [HW-1:0]   x_q, x_d;
    logic [DW-1:0]   mc_q, mc_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   p_q, p_d;
    logic            done_q, done_d;
    logic            finish;

    always_comb begin
`ifdef SQUARE_ITER_EARLY_EXIT_EN
        finish = (cnt_q == CNT_ONE) || (x_q[HW-1:1] == '0);
`else
        finish = (cnt_q == CNT_ONE);
`endif
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = a;
                    mc_d    = {{HW{1'b0}}, a};
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // The add result is forwarded straight into p on the final iteration.
                acc_d = x_q[0] ? (acc_q + mc_q) : acc_q;
                mc_d  = mc_q << 1;
                x_d   = x_q >> 1;
                cnt_d = cnt_q - CNT_ONE;
                if (finish) begin
                    p_d     = acc_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    // Datapath registers are fully reloaded on acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        x_q   <= x_d;
        mc_q  <= mc_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign p     = p_q;

endmodule

// File: tb/tb_square_iter.sv
// Scoreboard bench for square_iter: stimulus queues expected (p, completion cycle),
// a monitor after every rising edge checks done/p/ready against it.
module tb_square_iter;

    localparam int unsigned DW = 32;
    localparam int unsigned HW = DW / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [HW-1:0] a = '0;
    logic          done;
    logic [DW-1:0] p;

    square_iter #(.DW(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .ready(ready),
        .a    (a),
        .done (done),
        .p    (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] p;
        int unsigned   due;
        logic [HW-1:0] a;
    } exp_t;

    exp_t          sb[$];
    int unsigned   cyc = 0;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] held_p = '0;

    function automatic int unsigned model_latency(input logic [HW-1:0] op);
`ifdef SQUARE_ITER_EARLY_EXIT_EN
        int unsigned msb1 = 0;
        for (int unsigned i = 0; i < HW; i++)
            if (op[i]) msb1 = i + 1;
        return (msb1 == 0) ? 1 : msb1;
`else
        return HW;
`endif
    endfunction

    function automatic logic [DW-1:0] model_square(input logic [HW-1:0] op);
        longint unsigned v = longint'(op);
        return DW'(v * v);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: runs 1 time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                sb.delete();
                held_p = '0;
                check("rst_done", DW'(done), '0);
                check("rst_p", p, '0);
                check("rst_ready", DW'(ready), 1);
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", DW'(done), '0);
                    end else begin
                        e = sb.pop_front();
                        check("p", p, e.p);
                        check("latency", DW'(cyc), DW'(e.due));
                        held_p = e.p;
                    end
                end else begin
                    check("p_hold", p, held_p);
                    if (sb.size() != 0 && cyc > sb[0].due)
                        check("done_missing", DW'(cyc), DW'(sb[0].due));
                end
                check("ready", DW'(ready), DW'(sb.size() == 0));
            end
        end
    end

    // Called at a falling edge with ready=1: request is taken on the next rising edge.
    task automatic issue(input logic [HW-1:0] op);
        exp_t e;
        a     = op;
        start = 1'b1;
        e.a   = op;
        e.p   = model_square(op);
        e.due = cyc + 1 + model_latency(op);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout: ready=%0b required 1 after %0d cycles", ready, n);
        end
    endtask

    task automatic run_op(input logic [HW-1:0] op);
        @(negedge clk);
        wait_ready();
        issue(op);
        @(negedge clk);
        start = 1'b0;
        wait_ready();
    endtask

    initial begin
        logic [HW-1:0] r;
        int unsigned   n;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op('0);
        run_op('1);
        run_op(16'd46340);
        run_op(16'd5);
        run_op(16'd1);
        run_op(16'h8000);

        // start held high; a changes while busy and must be ignored until ready returns.
        @(negedge clk);
        wait_ready();
        issue(16'd3);
        @(negedge clk);
        a = 16'd7;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(16'd7);
        @(negedge clk);
        start = 1'b0;
        wait_ready();

        // Reset on COUNT edge 8 aborts the operation and clears p.
        @(negedge clk);
        issue(16'h1234);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd5);

        // Random traffic; while busy, start/a toggle randomly and must be ignored.
        for (int unsigned k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ready) begin
                if ($urandom_range(0, 3) != 0) begin
                    r = HW'($urandom);
                    case ($urandom_range(0, 7))
                        0: r = '0;
                        1: r = '1;
                        2: r = r >> $urandom_range(0, HW - 1);
                        default: ;
                    endcase
                    issue(r);
                end else begin
                    start = 1'b0;
                    a     = HW'($urandom);
                end
            end else begin
                start = 1'($urandom);
                a     = HW'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/square_iter.md
Name: square_iter

Overview:
- Iterative shift-and-add squarer. Computes p = a*a for an unsigned DW/2-bit operand and returns a DW-bit result.
- Inverse companion of the iterative integer square-root unit in lib/math. Shares its start/ready handshake style, so the two can be chained, e.g. for root checking or for generating squares in tables.
- Intended for low-area, non-pipelined use. One operation in flight at a time.

Parameters:
- DW, 32, result width in bits. Must be even and >= 4. Operand width is DW/2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request. Sampled only while ready=1.
- ready  out  1  high when idle and able to accept start
- a  in  DW/2  operand. Captured on the accepting edge.
- done  out  1  one-cycle pulse when p is updated
- p  out  DW  result a*a. Held stable until the next completion.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ready=1, done=0, p=0. The internal accumulator, multiplicand and counter are don't-care. Reset takes priority over all other inputs.
- States: IDLE, COUNT.
- ready is combinational: ready = (state == IDLE).
- IDLE:
  - If start=1: latch x <= a, mc <= zero-extended a (DW bits), acc <= 0, cnt <= DW/2. Go to COUNT.
  - If start=0: stay in IDLE.
  - done=0 in every IDLE cycle except the one immediately after completion.
- COUNT, one iteration per edge:
  - If x[0]=1: acc <= acc + mc (DW-bit add, no overflow possible).
  - mc <= mc << 1; x <= x >> 1; cnt <= cnt - 1.
  - When cnt==1 on this edge: p <= final acc (including this iteration's add), done <= 1, go to IDLE.
- Latency: start accepted at edge 0, result at edge DW/2. p and done are visible in the following cycle, together with ready=1. Throughput is one result per DW/2+1 cycles. A start may be accepted in the same cycle that done is high.
- start while ready=0 is ignored, not queued. a may change freely during COUNT.
- p is updated only on completion. Between operations it holds the last result.
- Reset during COUNT: the operation is aborted and p is cleared to 0. No done pulse is issued.
- Boundaries:
  - a=0 gives p=0.
  - a=2^(DW/2)-1 gives p = 2^DW - 2^(DW/2+1) + 1, which fits exactly in DW bits.

Optional Feature:
- Macro SQUARE_ITER_EARLY_EXIT_EN.
- Defined: in COUNT, completion happens on the edge where the shifted multiplier (x >> 1) becomes 0 or cnt==1, whichever comes first.
  - Latency = max(1, index of the highest set bit of a + 1) edges after acceptance.
  - a=0 completes on the first COUNT edge.
  - Results are identical to the macro-undefined build.
- Undefined: fixed DW/2-edge latency. This keeps timing deterministic for lockstep use.

Decomposition:
- Shared package math_pkg holds:
  - the state enum (IDLE, COUNT), reused by the sqrt unit;
  - a width-check function that asserts DW is even.
- No sub-module. The datapath is a single add and two shifts, kept inline.

Test Plan:
- DW=32, a=16'h0000, start pulse -> ready low 16 cycles, then done=1, p=32'h0000_0000. With the macro: done after 1 edge.
- a=16'hFFFF -> after 16 edges done=1, p=32'hFFFE_0001. Same latency with the macro.
- a=16'd46340 -> p=32'd2147395600. Feed p into the sqrt unit and check q=46340 (round trip).
- start held high with a changed mid-operation (first a=3, then a=7) -> first result p=9. Next accepted on a ready cycle with a=7 -> p=49.
- rst asserted at COUNT edge 8 of a=16'h1234 -> next cycle ready=1, p=0, no done. A new start with a=5 -> p=25.
- Macro defined, a=5 -> done 3 edges after acceptance, p=25. Randomized 10k operands match a*a in both builds.
